pipeline_perf_monitor: RTL
==========================

Name: pipeline_perf_monitor

Overview:
Synthesizable performance-counter block for the pipelined CPU. It moves the cycle, retired-instruction and stall accounting that the bench currently does ad hoc into RTL. Counts cycles, retired instructions, hazard stalls and NUM_EVT generic event lines, with a warm-up window, run/freeze control and a four-phase snapshot handshake into shadow registers. Sits beside the core, fed by the WB-stage regwrite/memwrite retire strobe and the hazard-unit stall signal; debug logic and the bench read it.

Parameters:
CNT_W, 64, width of every counter and of rd_data
NUM_EVT, 4, number of generic event inputs (1..16)
WARMUP_CYC, 0, cycles ignored after start before counting begins (0 = none)
SEL_W, $clog2(NUM_EVT+3), width of rd_sel (derived, not overridden)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin measurement
stop  in  1  pulse: freeze counters
clear  in  1  synchronous: zero counters and ovf, return to IDLE
retire  in  1  one instruction retired this cycle
stall  in  1  pipeline stalled this cycle
evt  in  NUM_EVT  generic event strobes, one bit per counter
snap_req  in  1  snapshot request, four-phase handshake
snap_ack  out  1  snapshot acknowledge
rd_sel  in  SEL_W  shadow index: 0 cycles, 1 retired, 2 stalls, 3+k evt[k]
rd_data  out  CNT_W  registered shadow value selected by rd_sel
ovf  out  NUM_EVT+3  sticky per-counter overflow, same index order as rd_sel
state  out  2  current FSM state (IDLE=0, WARMUP=1, RUN=2, FROZEN=3)

Behaviour:
- Reset (rst_n low, async): state=IDLE; all counters, shadows, ovf, snap_ack and rd_data = 0.
- FSM:
  - IDLE --start--> WARMUP if WARMUP_CYC>0, else RUN.
  - WARMUP: internal counter runs to WARMUP_CYC-1, then RUN. Events are ignored during WARMUP.
  - RUN --stop--> FROZEN.
  - FROZEN --start--> RUN, resuming without zeroing.
  - clear from any state --> IDLE.
- Priority when inputs coincide: clear > stop > start. start in RUN or WARMUP is ignored. stop in IDLE or WARMUP goes to FROZEN.
- Counting: only in RUN. Per cycle, cycles+1, retired+retire, stalls+stall, evt_cnt[k]+evt[k]. A counter is visible incremented the cycle after its input is sampled. The cycle in which stop is sampled is still counted. The cycle in which start is sampled is not counted.
- Overflow: an increment at all-ones wraps to 0 and sets the matching ovf bit. ovf bits stay set until clear or reset.
- Snapshot handshake:
  - snap_req sampled high with snap_ack low: all shadows load the live counter values, including that cycle's increments. snap_ack rises the next cycle.
  - snap_ack stays high while snap_req stays high. It falls the cycle after snap_req is sampled low.
  - No new capture happens until snap_ack has returned low.
  - clear does not disturb the shadows or the handshake.
- Read: rd_data <= shadow[rd_sel], one-cycle latency. rd_sel >= NUM_EVT+3 returns 0.
- clear coinciding with a counting cycle: the counters go to 0; the increment is discarded.

Optional Feature:
PERF_SATURATE_EN. When defined, a counter at all-ones holds at all-ones instead of wrapping, and the ovf bit is still set. When undefined, counters wrap modulo 2^CNT_W.

Decomposition:
- Package perf_pkg holds:
  - state enum perf_state_e (IDLE/WARMUP/RUN/FROZEN);
  - counter index constants IDX_CYCLES=0, IDX_RETIRED=1, IDX_STALLS=2, IDX_EVT0=3.
- Sub-module perf_counter (CNT_W): holds the enable/inc/clear logic, saturate-or-wrap behaviour and the sticky ovf bit. The top instantiates NUM_EVT+3 of them in a generate loop.

Test Plan:
- Reset, start, 10 cycles with retire=1 and stall every 2nd cycle, stop, snapshot -> rd_sel 0/1/2 return 10/10/5; state=FROZEN.
- WARMUP_CYC=4: start, then retire held high for 10 cycles, then stop -> retired=6, cycles=6.
- CNT_W=4, retire held high for 17 RUN cycles -> retired=1, ovf[1]=1. With PERF_SATURATE_EN -> retired=15, ovf[1]=1.
- Handshake: hold snap_req 5 cycles -> exactly one capture, snap_ack high 5 cycles, low 1 cycle after snap_req drops. A second req while ack is high gives no recapture.
- Simultaneous clear+stop+start in RUN -> state=IDLE, counters and ovf 0, shadows unchanged. rd_sel=NUM_EVT+3 -> rd_data 0.
- Async reset mid-RUN with snap_ack high -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared types and counter index map for pipeline_perf_monitor.
// Index order is shared by rd_sel, ovf and the counter bank.
package perf_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2,
    StFrozen = 2'd3
  } perf_state_e;

  localparam int unsigned IDX_CYCLES  = 0;
  localparam int unsigned IDX_RETIRED = 1;
  localparam int unsigned IDX_STALLS  = 2;
  localparam int unsigned IDX_EVT0    = 3;

  // Total counters for a given number of generic event lines.
  function automatic int unsigned num_counters(input int unsigned num_evt);
    return num_evt + IDX_EVT0;
  endfunction

endpackage

// File: rtl/pipeline_perf_monitor_counter.sv
// Single performance counter with synchronous clear and sticky overflow flag.
// PERF_SATURATE_EN: hold at all-ones on overflow instead of wrapping.
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_upd;
  logic             ovf_q, ovf_d, ovf_upd;
  logic             at_max;

  assign at_max = &cnt_q;

  // cnt_upd is the incremented value ignoring clear; snapshots use it.
  always_comb begin
    cnt_upd = cnt_q;
    ovf_upd = ovf_q;
    if (en_i && inc_i) begin
      if (at_max) begin
        ovf_upd = 1'b1;
`ifdef PERF_SATURATE_EN
        cnt_upd = cnt_q;
`else
        cnt_upd = '0;
`endif
      end else begin
        cnt_upd = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_upd;
    ovf_d = ovf_upd;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_next_o = cnt_upd;
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Performance monitor: cycle/retire/stall/event counters, warm-up, run/freeze,
// snapshot into shadow registers. Optional macro PERF_SATURATE_EN (see perf_counter).
module pipeline_perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned  CNT_W      = 64,
  parameter int unsigned  NUM_EVT    = 4,
  parameter int unsigned  WARMUP_CYC = 0,
  localparam int unsigned SEL_W      = $clog2(NUM_EVT + 3)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               retire,
  input  logic               stall,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               snap_req,
  output logic               snap_ack,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT+2:0] ovf,
  output logic [1:0]         state
);

  localparam int unsigned NumCnt = num_counters(NUM_EVT);

  perf_state_e state_q, state_d;
  logic [31:0] warm_q, warm_d;

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    if (clear) begin
      state_d = StIdle;
    end else if (stop) begin
      state_d = StFrozen;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = (WARMUP_CYC > 0) ? StWarmup : StRun;
            warm_d  = '0;
          end
        end
        StWarmup: begin
          if (warm_q == 32'(WARMUP_CYC - 1)) begin
            state_d = StRun;
          end else begin
            warm_d = warm_q + 32'd1;
          end
        end
        StRun: ;
        StFrozen: begin
          if (start) begin
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  assign state = state_q;

  // Counter bank; bit order matches the rd_sel index map.
  logic             count_en;
  logic [NumCnt-1:0] inc_vec;
  logic [CNT_W-1:0] cnt_next [NumCnt];

  assign count_en = (state_q == StRun);
  assign inc_vec  = {evt, stall, retire, 1'b1};

  for (genvar g = 0; g < NumCnt; g++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (count_en),
      .inc_i      (inc_vec[g]),
      .clr_i      (clear),
      .cnt_next_o (cnt_next[g]),
      .ovf_o      (ovf[g])
    );
  end

  // Four-phase handshake: ack simply follows req one cycle late, and a capture
  // fires only on the rising request seen while ack is still low.
  logic snap_ack_q, snap_ack_d;
  logic capture;

  assign capture    = snap_req && !snap_ack_q;
  assign snap_ack_d = snap_req;

  logic [CNT_W-1:0] shadow_q [NumCnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_ack_q <= 1'b0;
      for (int i = 0; i < NumCnt; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      snap_ack_q <= snap_ack_d;
      if (capture) begin
        for (int i = 0; i < NumCnt; i++) begin
          shadow_q[i] <= cnt_next[i];
        end
      end
    end
  end

  assign snap_ack = snap_ack_q;

  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i < NumCnt; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
